// File: rtl/frame_sequencer_if.sv
// Handshake bundle between game logic, frame sequencer and renderer.
// The sequencer owns the slave side; the game/renderer side is the master.
interface frame_sequencer_if;
  logic       vsync;
  logic       start;
  logic [9:0] pac_x_in;
  logic [9:0] pac_y_in;
  logic [9:0] g_x_in;
  logic [9:0] g_y_in;
  logic [7:0] eaten;
  logic       collide;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] g_x;
  logic [9:0] g_y;
  logic [7:0] dead;
  logic       p_dead;
  logic       tick;
  logic       respawn;
  logic [1:0] lives;
  logic [2:0] state;

  modport master (
    output vsync, start,
    output pac_x_in, pac_y_in,
    output g_x_in, g_y_in,
    output eaten, collide,
    input  x, y, g_x, g_y,
    input  dead, p_dead,
    input  tick, respawn,
    input  lives, state
  );

  modport slave (
    input  vsync, start,
    input  pac_x_in, pac_y_in,
    input  g_x_in, g_y_in,
    input  eaten, collide,
    output x, y, g_x, g_y,
    output dead, p_dead,
    output tick, respawn,
    output lives, state
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame-synchronous game-state controller: vsync-paced play,
// double-buffered sprite positions, cookie mask and life/death FSM.
module frame_sequencer #(
  parameter int LIVES      = 3,
  parameter int DIE_FRAMES = 60,
  parameter int PAC_X0     = 310,
  parameter int PAC_Y0     = 300,
  parameter int GH_X0      = 80,
  parameter int GH_Y0      = 80
) (
  input logic             dclk,
  input logic             clr,
  frame_sequencer_if.slave bus
);

  localparam logic [9:0] PX = PAC_X0[9:0];
  localparam logic [9:0] PY = PAC_Y0[9:0];
  localparam logic [9:0] GX = GH_X0[9:0];
  localparam logic [9:0] GY = GH_Y0[9:0];
  localparam logic [1:0] LV = LIVES[1:0];
  localparam logic [7:0] DF = DIE_FRAMES[7:0];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESPAWN = 3'd1,
    PLAY    = 3'd2,
    DYING   = 3'd3,
    OVER    = 3'd4,
    WIN     = 3'd5
  } st_t;

  st_t        st;
  logic       vsync_q;
  logic       pend;
  logic [7:0] die_cnt;
  logic       fe;
  logic [7:0] mask_nx;
  logic       hit;

  assign fe      = vsync_q & ~bus.vsync;
  assign mask_nx = bus.dead | bus.eaten;
  assign hit     = pend | bus.collide;
  assign bus.state = st;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      st          <= IDLE;
      vsync_q     <= 1'b0;
      pend        <= 1'b0;
      die_cnt     <= 8'd0;
      bus.x       <= PX;
      bus.y       <= PY;
      bus.g_x     <= GX;
      bus.g_y     <= GY;
      bus.dead    <= 8'd0;
      bus.p_dead  <= 1'b0;
      bus.tick    <= 1'b0;
      bus.respawn <= 1'b0;
      bus.lives   <= LV;
    end else begin
      vsync_q     <= bus.vsync;
      bus.tick    <= 1'b0;
      bus.respawn <= 1'b0;
      unique case (st)
        IDLE, OVER, WIN: begin
          if (bus.start) begin
            st          <= RESPAWN;
            bus.respawn <= 1'b1;
            bus.lives   <= LV;
            bus.dead    <= 8'd0;
            bus.p_dead  <= 1'b0;
            bus.x       <= PX;
            bus.y       <= PY;
            bus.g_x     <= GX;
            bus.g_y     <= GY;
          end
        end
        RESPAWN: begin
          pend <= 1'b0;
          if (fe) st <= PLAY;
        end
        PLAY: begin
          bus.dead <= mask_nx;
          if (bus.collide) pend <= 1'b1;
          if (fe) begin
            bus.x    <= bus.pac_x_in;
            bus.y    <= bus.pac_y_in;
            bus.g_x  <= bus.g_x_in;
            bus.g_y  <= bus.g_y_in;
            bus.tick <= 1'b1;
            // clearing the board outranks a same-frame collision
            if (mask_nx == 8'hFF) begin
              st <= WIN;
            end else if (hit) begin
              st         <= DYING;
              bus.lives  <= bus.lives - 2'd1;
              die_cnt    <= DF;
              bus.p_dead <= 1'b1;
            end
          end
        end
        DYING: begin
          if (fe) begin
            die_cnt <= die_cnt - 8'd1;
            if (die_cnt == 8'd1) begin
              if (bus.lives == 2'd0) begin
                st <= OVER;
              end else begin
                st          <= RESPAWN;
                bus.respawn <= 1'b1;
                bus.p_dead  <= 1'b0;
                bus.x       <= PX;
                bus.y       <= PY;
                bus.g_x     <= GX;
                bus.g_y     <= GY;
              end
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Game-state controller that sits between the game logic (pac/ghost movement, collision, cookie detection) and the VGA renderer. It sequences play frame-by-frame off the renderer's vsync, double-buffers sprite positions so the renderer never sees a mid-frame update, accumulates the eaten-cookie mask, and runs the life / death / win state machine that drives the renderer's `dead` and `p_dead` inputs.

## Interface
Parameters:
- `LIVES`, 3: lives at new game; range 1..3.
- `DIE_FRAMES`, 60: frames spent in DYING; range 1..255.
- `PAC_X0`, 310: pac spawn x. `PAC_Y0`, 300: pac spawn y.
- `GH_X0`, 80: ghost spawn x. `GH_Y0`, 80: ghost spawn y.

Ports:
- `dclk`  in  1  pixel clock, 25 MHz.
- `clr`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  active-low vsync from the VGA timing generator, same clock domain.
- `start`  in  1  level, new-game request.
- `pac_x_in`, `pac_y_in`, `g_x_in`, `g_y_in`  in  10 each  live positions from game logic.
- `eaten`  in  8  per-cookie eaten flags, any cycle.
- `collide`  in  1  pac/ghost overlap, any cycle.
- `x`, `y`, `g_x`, `g_y`  out  10 each  frame-stable positions to renderer.
- `dead`  out  8  sticky eaten-cookie mask to renderer.
- `p_dead`  out  1  death / game-over indication to renderer.
- `tick`  out  1  one-cycle game-update strobe, once per frame in PLAY.
- `respawn`  out  1  one-cycle strobe: game logic reloads spawn positions.
- `lives`  out  2  remaining lives.
- `state`  out  3  IDLE=0, RESPAWN=1, PLAY=2, DYING=3, OVER=4, WIN=5.

## Operation
- Frame edge `fe` = `vsync_q & ~vsync`, where `vsync_q` is `vsync` registered on `dclk`. All state work except start/eaten/collide capture happens on `fe`.
- IDLE (after reset): positions equal spawn params, `dead`=0, `lives`=LIVES, `p_dead`=0. `start`=1 -> RESPAWN. `respawn` pulses on that transition.
- RESPAWN: outputs hold spawn positions; collide_pending cleared. On `fe` -> PLAY.
- PLAY:
  - Every cycle: `dead <= dead | eaten`; `collide`=1 sets collide_pending.
  - On `fe`: latch the four `*_in` values into `x`/`y`/`g_x`/`g_y`; pulse `tick`.
  - On the same `fe`, priority order:
    1. Mask complete (`dead | eaten` == 8'hFF) -> WIN.
    2. collide_pending -> DYING: `lives` decrements, die counter loads DIE_FRAMES, `p_dead`=1.
  - A win on the last cookie takes priority over a simultaneous collision.
- DYING: positions frozen, `tick` not asserted. Each `fe` decrements the counter. On the `fe` where it reaches 0: `lives`==0 -> OVER, else -> RESPAWN with `respawn` pulse and `p_dead`=0.
- OVER: `p_dead`=1.
- WIN: `p_dead`=0 and positions frozen.
- OVER/WIN exit: `start`=1 -> new game: `lives`=LIVES, `dead`=0, `p_dead`=0, -> RESPAWN with `respawn` pulse.
- `start` is ignored in RESPAWN, PLAY and DYING.
- `eaten` and `collide` are ignored outside PLAY.
- Widths: `lives` never underflows, since it decrements only on DYING entry and DYING exits to OVER at 0. The die counter is 8 bits.

## Timing
- All outputs are registered. Reset values match IDLE values; `tick`=0, `respawn`=0, `state`=0.
- `clr` asserted mid-frame or mid-DYING: immediate asynchronous return to IDLE values; the counter and collide_pending clear.
- Position latency: `*_in` sampled at the `dclk` edge where `fe`=1; the new `x`/`y`/`g_x`/`g_y` and `tick`=1 are visible in the following cycle. `tick` is high for exactly 1 cycle.
- `vsync` falls at vc=0, so positions change during vertical blanking and stay constant through the active region (vc 31..510).
- `start` is recognised on the first rising edge it is sampled high in IDLE/OVER/WIN. `respawn` is high the next cycle.
- A `collide` pulse of a single cycle anywhere in a PLAY frame is captured and acted on at the next `fe`.
- DYING spans exactly DIE_FRAMES frame edges.

## Test plan
- Reset, then `start`=1 for 1 cycle -> `respawn` 1-cycle pulse. `state` goes 1 then, at the next vsync fall, 2. `x`=310, `y`=300, `g_x`=80, `g_y`=80, `lives`=3.
- PLAY, drive `pac_x_in`=123 mid-frame -> `x` stays at its old value until vsync falls. It reads 123 one cycle after the edge, together with a single-cycle `tick`.
- Pulse `eaten`=8'h01, later 8'h80 -> `dead`=8'h81 and sticky. Then `eaten`=8'h7E -> WIN (`state`=5) at the next vsync fall; `tick` stops.
- 1-cycle `collide` in PLAY -> at next `fe`: `state`=3, `p_dead`=1, `lives`=2. After 60 frame edges: `state`=1, `respawn` pulse, `p_dead`=0.
- Three collisions from LIVES=3 -> `lives`=0 and after the die interval `state`=4 with `p_dead`=1. `start` -> `lives`=3, `dead`=0, `state`=1.
- `collide` and the final cookie in the same frame -> WIN with `lives` unchanged. `clr` pulse during DYING -> IDLE values immediately.
